fir_log_reader: RTL and testbench
=================================

FIR_LOG_READER -- requirements
Module: fir_log_reader

Interface
REQ-001 Parameter NB_DATA, default 8: width of the logged signed sample.
REQ-002 Parameter NB_ADDR, default 5: log address width; DEPTH = 2**NB_ADDR (32).
REQ-003 The module SHALL have port i_clock  input  1  system clock; all state updates on its rising edge.
REQ-004 The module SHALL have port i_reset  input  1  asynchronous, active-low reset.
REQ-005 The module SHALL have port i_enable  input  1  sample strobe; i_data is valid when high.
REQ-006 The module SHALL have port i_data  input  NB_DATA  signed sample from the generator/FIR chain.
REQ-007 The module SHALL have port i_run  input  1  start-capture request.
REQ-008 The module SHALL have port i_stop  input  1  abort capture, keeping the samples logged so far.
REQ-009 The module SHALL have port i_read_start  input  1  start-readout request.
REQ-010 The module SHALL have port i_ready  input  1  downstream ready for readout.
REQ-011 The module SHALL have port o_data  output  NB_DATA  signed readout sample.
REQ-012 The module SHALL have port o_valid  output  1  o_data valid.
REQ-013 The module SHALL have port o_count  output  NB_ADDR+1  number of samples logged.
REQ-014 The module SHALL have port o_busy  output  1  high in CAPTURE or READ.
REQ-015 The module SHALL have port o_done  output  1  high in DONE.

Function
REQ-016 The FSM SHALL have states IDLE, CAPTURE, DONE and READ; the log SHALL be a DEPTH x NB_DATA register array.
REQ-017 In IDLE, an i_run sampled high SHALL go to CAPTURE and clear the write pointer and o_count; the i_run cycle itself SHALL write no sample.
REQ-018 In CAPTURE, each cycle with i_enable=1 SHALL write i_data at the write pointer, then increment the pointer and o_count; cycles with i_enable=0 SHALL write nothing.
REQ-019 In CAPTURE, the write of sample DEPTH SHALL move the FSM to DONE on the same edge, with o_count = DEPTH and no pointer wrap.
REQ-020 In CAPTURE, i_stop=1 SHALL move to DONE; a simultaneous i_enable sample SHALL NOT be written.
REQ-021 In CAPTURE, i_stop with o_count=0 SHALL still move to DONE.
REQ-022 In CAPTURE, i_run and i_read_start SHALL be ignored.
REQ-023 In DONE, i_run SHALL restart capture as in REQ-017.
REQ-024 In DONE, i_read_start SHALL go to READ and clear the read pointer.
REQ-025 In DONE, if i_run and i_read_start are both high, i_run SHALL win.
REQ-026 In DONE, i_read_start with o_count=0 SHALL return to DONE after one READ cycle, with o_valid never asserted.
REQ-027 In READ, when o_valid=0 or i_ready=1, and unread samples remain, the block SHALL load o_data = log[read pointer], set o_valid=1, and increment the read pointer.
REQ-028 In READ, when a handshake (o_valid & i_ready) occurs and no samples remain, the block SHALL set o_valid=0 and go to DONE.
REQ-029 The first o_valid SHALL rise 2 cycles after i_read_start is sampled.
REQ-030 With i_ready held high, the block SHALL deliver one sample per cycle.
REQ-031 While o_valid=1 and i_ready=0, o_data and o_valid SHALL hold stable.
REQ-032 Each logged sample SHALL be delivered exactly once, in write order.
REQ-033 In READ, i_run, i_stop and i_read_start SHALL be ignored.
REQ-034 Readout SHALL NOT alter the log or o_count; a repeated readout SHALL return identical data.
REQ-035 o_data SHALL be a bit-exact copy of the logged sample, with no sign extension or truncation.

Reset
REQ-036 On i_reset=0, asynchronously: state = IDLE, both pointers = 0, o_count = 0, o_valid = 0, o_data = 0, o_busy = 0, o_done = 0.
REQ-037 The log array SHALL NOT need a reset; its contents are don't-care until rewritten.
REQ-038 Reset asserted mid-CAPTURE or mid-READ SHALL abort immediately, and no handshake SHALL complete in that cycle.
REQ-039 After reset release, a new i_run SHALL be required before any capture.

Verification
REQ-040 Reset: assert i_reset=0 mid-stream -> all outputs 0 within the same cycle, and FSM in IDLE.
REQ-041 Full capture: i_run, then 40 cycles of i_enable=1 with ramp i_data 0..39 -> o_count=32, o_done=1; readout with i_ready=1 -> o_data 0..31 on 32 consecutive cycles, then o_valid=0, o_done=1.
REQ-042 Backpressure: log 32 samples, read with i_ready toggling in a 1-0-0-1 pattern -> o_data held during stalls, output 0..31 with no loss or duplicates.
REQ-043 Abort: 10 samples (-5..4) then i_stop together with i_enable -> o_count=10; readout returns -5..4 only.
REQ-044 Gaps and priority: i_enable alternating 1/0 over 20 cycles -> o_count=10; in DONE, i_run and i_read_start together -> CAPTURE with o_count=0, and o_valid never asserted.
REQ-045 Reset mid-READ after 5 handshakes -> o_valid=0, IDLE; i_read_start in IDLE ignored; a new i_run is required.

Source files
------------

// File: rtl/fir_log_reader_if.sv
// fir_log_reader_if
//   Bundles the capture strobes, the readout handshake and the status
//   outputs of fir_log_reader. Clock and reset stay outside as plain ports.
//   slave  : view used by fir_log_reader (capture/readout engine)
//   master : view used by whatever drives the logger (generator side / sink)
//   Signals:
//     i_enable, i_data   sample strobe and signed sample
//     i_run, i_stop      start / abort capture
//     i_read_start       start readout
//     i_ready            downstream ready
//     o_data, o_valid    readout sample and its valid
//     o_count            number of samples logged
//     o_busy, o_done     status (CAPTURE/READ, DONE)
interface fir_log_reader_if #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 5
);
  logic                      i_enable;
  logic signed [NB_DATA-1:0] i_data;
  logic                      i_run;
  logic                      i_stop;
  logic                      i_read_start;
  logic                      i_ready;
  logic signed [NB_DATA-1:0] o_data;
  logic                      o_valid;
  logic [NB_ADDR:0]          o_count;
  logic                      o_busy;
  logic                      o_done;

  modport slave (
    input  i_enable, i_data, i_run, i_stop, i_read_start, i_ready,
    output o_data, o_valid, o_count, o_busy, o_done
  );

  modport master (
    output i_enable, i_data, i_run, i_stop, i_read_start, i_ready,
    input  o_data, o_valid, o_count, o_busy, o_done
  );
endinterface

// File: rtl/fir_log_reader.sv
// fir_log_reader
//   Captures up to 2**NB_ADDR signed samples from a generator/FIR chain into
//   a register log, then streams them out in write order over a
//   valid/ready handshake. States: IDLE, CAPTURE, DONE, READ.
//   Ports:
//     i_clock  system clock, rising edge
//     i_reset  asynchronous active-low reset
//     bus      fir_log_reader_if.slave (strobes, readout handshake, status)
module fir_log_reader #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 5
) (
  input  logic              i_clock,
  input  logic              i_reset,
  fir_log_reader_if.slave   bus
);

  localparam int DEPTH = 2**NB_ADDR;
  localparam logic [NB_ADDR:0] LAST_C = (NB_ADDR+1)'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE, READ} state_t;

  state_t                    state_q, state_d;
  // count_q doubles as the write pointer; the extra bit lets it reach DEPTH
  // without wrapping.
  logic [NB_ADDR:0]          count_q, count_d;
  logic [NB_ADDR:0]          rptr_q, rptr_d;
  logic                      valid_q, valid_d;
  logic signed [NB_DATA-1:0] data_q, data_d;
  logic                      we;

  logic signed [NB_DATA-1:0] log_mem [DEPTH];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rptr_d  = rptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    we      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_run) begin
          state_d = CAPTURE;
          count_d = '0;
        end
      end
      CAPTURE: begin
        // Stop beats a simultaneous sample.
        if (bus.i_stop) begin
          state_d = DONE;
        end else if (bus.i_enable) begin
          we      = 1'b1;
          count_d = count_q + 1'b1;
          if (count_q == LAST_C) state_d = DONE;
        end
      end
      DONE: begin
        // Restart has priority over readout.
        if (bus.i_run) begin
          state_d = CAPTURE;
          count_d = '0;
        end else if (bus.i_read_start) begin
          state_d = READ;
          rptr_d  = '0;
        end
      end
      READ: begin
        // Output register is free when empty or being consumed this cycle.
        if (!valid_q || bus.i_ready) begin
          if (rptr_q < count_q) begin
            data_d  = log_mem[rptr_q[NB_ADDR-1:0]];
            valid_d = 1'b1;
            rptr_d  = rptr_q + 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      count_q <= '0;
      rptr_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  // Log storage carries no reset; entries are rewritten before being read.
  always_ff @(posedge i_clock) begin
    if (we) log_mem[count_q[NB_ADDR-1:0]] <= bus.i_data;
  end

  assign bus.o_data  = data_q;
  assign bus.o_valid = valid_q;
  assign bus.o_count = count_q;
  assign bus.o_busy  = (state_q == CAPTURE) || (state_q == READ);
  assign bus.o_done  = (state_q == DONE);

endmodule

// File: tb/tb_fir_log_reader.sv
module tb_fir_log_reader;
  localparam int NB_DATA = 8;
  localparam int NB_ADDR = 5;
  localparam int DEPTH   = 2**NB_ADDR;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  // Reference model: the log is a queue of the samples that should be kept.
  int   logq[$];
  bit   capturing;

  fir_log_reader_if #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) bus ();

  fir_log_reader #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_enable     = 1'b0;
    bus.i_data       = '0;
    bus.i_run        = 1'b0;
    bus.i_stop       = 1'b0;
    bus.i_read_start = 1'b0;
    bus.i_ready      = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, int'(bus.o_valid), 0);
    chk({tag, "_data"},  int'(bus.o_data),  0);
    chk({tag, "_count"}, int'(bus.o_count), 0);
    chk({tag, "_busy"},  int'(bus.o_busy),  0);
    chk({tag, "_done"},  int'(bus.o_done),  0);
  endtask

  task automatic start_run();
    bus.i_run = 1'b1;
    step();
    bus.i_run = 1'b0;
    logq.delete();
    capturing = 1'b1;
    chk("run_count", int'(bus.o_count), 0);
    chk("run_busy",  int'(bus.o_busy),  1);
  endtask

  // One capture cycle; model: stop discards the sample, a full log ends capture.
  task automatic cap_cycle(input bit en, input int d, input bit stop);
    bus.i_enable = en;
    bus.i_data   = NB_DATA'(d);
    bus.i_stop   = stop;
    step();
    bus.i_enable = 1'b0;
    bus.i_stop   = 1'b0;
    if (capturing) begin
      if (stop) capturing = 1'b0;
      else if (en) begin
        logq.push_back(d);
        if (logq.size() == DEPTH) capturing = 1'b0;
      end
    end
    chk("cap_count", int'(bus.o_count), logq.size());
    chk("cap_done",  int'(bus.o_done),  capturing ? 0 : 1);
  endtask

  // mode 0: ready always high, 1: 1-0-0-1 pattern, 2: random ready
  task automatic read_all(input int mode);
    int   idx;
    int   cyc;
    bit   rdy;
    bit   pv;
    bit   pr;
    int   pd;
    bit   seen_valid;
    bit   pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    bus.i_read_start = 1'b1;
    bus.i_ready      = 1'b0;
    step();
    bus.i_read_start = 1'b0;
    chk("rd_lat0", int'(bus.o_valid), 0);
    chk("rd_busy", int'(bus.o_busy),  1);
    idx = 0; cyc = 0; seen_valid = 1'b0;
    while (!bus.o_done && cyc < 400) begin
      if (mode == 0)      rdy = 1'b1;
      else if (mode == 1) rdy = pat[cyc % 4];
      else                rdy = 1'($urandom_range(0, 1));
      bus.i_ready = rdy;
      if (cyc == 1) chk("rd_lat1", int'(bus.o_valid), (logq.size() > 0) ? 1 : 0);
      if (bus.o_valid) seen_valid = 1'b1;
      if (bus.o_valid && rdy) begin
        chk("rd_data", int'(bus.o_data), (idx < logq.size()) ? logq[idx] : -9999);
        idx++;
      end
      pv = bus.o_valid; pr = rdy; pd = int'(bus.o_data);
      step();
      cyc++;
      if (pv && !pr) begin
        chk("hold_valid", int'(bus.o_valid), 1);
        chk("hold_data",  int'(bus.o_data),  pd);
      end
    end
    bus.i_ready = 1'b0;
    chk("rd_timeout", (cyc < 400) ? 1 : 0, 1);
    if (mode == 0) chk("rd_cycles", cyc, logq.size() + 1);
    if (logq.size() == 0) chk("rd_novalid", int'(seen_valid), 0);
    chk("rd_n",     idx, logq.size());
    chk("rd_valid", int'(bus.o_valid), 0);
    chk("rd_done",  int'(bus.o_done),  1);
    chk("rd_count", int'(bus.o_count), logq.size());
  endtask

  initial begin
    n_chk = 0; n_bad = 0;
    capturing = 1'b0;
    idle_inputs();
    rst_n = 1'b0;
    #2;
    chk_all_zero("rst0");
    step(); step();
    rst_n = 1'b1;
    step();

    // read_start in IDLE does nothing
    bus.i_read_start = 1'b1;
    step();
    bus.i_read_start = 1'b0;
    chk("idle_rs_busy", int'(bus.o_busy), 0);
    chk("idle_rs_done", int'(bus.o_done), 0);

    // full capture with ramp 0..39, readouts with and without backpressure
    start_run();
    for (int i = 0; i < 40; i++) cap_cycle(1'b1, i, 1'b0);
    chk("full_count", int'(bus.o_count), 32);
    read_all(0);
    read_all(1);

    // abort: -5..4 then stop together with enable
    start_run();
    for (int i = -5; i < 5; i++) cap_cycle(1'b1, i, 1'b0);
    cap_cycle(1'b1, 99, 1'b1);
    chk("abort_count", int'(bus.o_count), 10);
    read_all(2);

    // gaps: alternating enable
    start_run();
    for (int i = 0; i < 20; i++) cap_cycle(i % 2 == 0, 100 - i, 1'b0);
    cap_cycle(1'b0, 0, 1'b1);
    chk("gap_count", int'(bus.o_count), 10);
    // run + read_start in DONE: run wins
    bus.i_run = 1'b1; bus.i_read_start = 1'b1; bus.i_ready = 1'b1;
    step();
    bus.i_run = 1'b0; bus.i_read_start = 1'b0;
    logq.delete(); capturing = 1'b1;
    chk("prio_busy",  int'(bus.o_busy),  1);
    chk("prio_done",  int'(bus.o_done),  0);
    chk("prio_count", int'(bus.o_count), 0);
    chk("prio_valid", int'(bus.o_valid), 0);
    // run / read_start ignored in CAPTURE, then stop with an empty log
    bus.i_run = 1'b1; bus.i_read_start = 1'b1;
    cap_cycle(1'b1, -7, 1'b0);
    bus.i_run = 1'b0; bus.i_read_start = 1'b0; bus.i_ready = 1'b0;
    cap_cycle(1'b0, 0, 1'b1);
    start_run();
    cap_cycle(1'b1, 5, 1'b1);
    chk("empty_count", int'(bus.o_count), 0);
    read_all(0);

    // randomized captures and readouts
    for (int it = 0; it < 8; it++) begin
      start_run();
      for (int c = 0; c < 60 && capturing; c++)
        cap_cycle(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)) - 128,
                  ($urandom_range(0, 49) == 0));
      if (capturing) cap_cycle(1'b0, 0, 1'b1);
      read_all(2);
      if (it % 3 == 0) read_all(0);
    end

    // reset in the middle of a readout
    start_run();
    for (int i = 0; i < 32; i++) cap_cycle(1'b1, int'($urandom_range(0, 255)) - 128, 1'b0);
    bus.i_read_start = 1'b1;
    step();
    bus.i_read_start = 1'b0;
    bus.i_ready = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("mid_data", int'(bus.o_data), logq[i]);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    step();
    chk_all_zero("rst_hold");
    bus.i_ready = 1'b0;
    rst_n = 1'b1;
    step();
    bus.i_read_start = 1'b1;
    step();
    bus.i_read_start = 1'b0;
    chk("post_rs_busy", int'(bus.o_busy), 0);
    bus.i_enable = 1'b1; bus.i_data = 8'sd3;
    step(); step();
    bus.i_enable = 1'b0;
    chk("post_norun_count", int'(bus.o_count), 0);
    chk("post_norun_busy",  int'(bus.o_busy),  0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
